// File: rtl/gray_pkg.sv
// Shared constants for the Gray counter control path: state codes, default
// timing values and the direction encoding also used by gray_counter_top.
package gray_pkg;

    localparam logic ST_PAUSED = 1'b0;
    localparam logic ST_RUN    = 1'b1;

    localparam int DIV_COUNT_DEF = 100_000_000;  // 1 Hz tick at 100 MHz
    localparam int DB_COUNT_DEF  = 1_000_000;    // 10 ms hold at 100 MHz

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw board input and accepts a new level only after it has
// held for DB_COUNT cycles; rise is a one-cycle pulse on each accepted 0->1.
module btn_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_COUNT    = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int              CW       = $clog2(DB_COUNT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d    = '0;
        stable_d = stable_q;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

    assign level = stable_q;
    assign rise  = stable_q & ~prev_q;

endmodule

// File: rtl/gray_tick_ctrl.sv
// Run/pause/step control for gray_counter_top: debounced buttons, RUN-mode
// prescaler and a one-cycle cnt_en pulse. Define GRAY_TICK_AUTORUN_EN to leave reset in RUN.
module gray_tick_ctrl
    import gray_pkg::*;
#(
    parameter int DIV_COUNT   = DIV_COUNT_DEF,
    parameter int DB_COUNT    = DB_COUNT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    input  logic dir_sw,
    output logic cnt_en,
    output logic cnt_dir,
    output logic running
);

    localparam int            PW         = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_COUNT - 1);

`ifdef GRAY_TICK_AUTORUN_EN
    localparam logic RESET_STATE = ST_RUN;
`else
    localparam logic RESET_STATE = ST_PAUSED;
`endif

    logic          state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          cnt_en_q, cnt_en_d;
    logic          dir_q, dir_d;
    logic          running_q, running_d;

    logic run_rise, step_rise, dir_level;
    logic run_level_unused, step_level_unused, dir_rise_unused;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_COUNT(DB_COUNT)) u_db_run (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_run),
        .level (run_level_unused),
        .rise  (run_rise)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_COUNT(DB_COUNT)) u_db_step (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_step),
        .level (step_level_unused),
        .rise  (step_rise)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_COUNT(DB_COUNT)) u_db_dir (
        .clk   (clk),
        .rst   (rst),
        .raw   (dir_sw),
        .level (dir_level),
        .rise  (dir_rise_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            presc_q   <= '0;
            cnt_en_q  <= 1'b0;
            dir_q     <= DIR_UP;
            running_q <= RESET_STATE;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_en_q  <= cnt_en_d;
            dir_q     <= dir_d;
            running_q <= running_d;
        end
    end

    // Prescaler is held at 0 while paused, so entering RUN always restarts the period.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        case (state_q)
            ST_PAUSED: begin
                if (run_rise) state_d = ST_RUN;
            end
            default: begin
                if (run_rise) begin
                    state_d = ST_PAUSED;
                end else if (presc_q != PRESC_LAST) begin
                    presc_d = presc_q + PW'(1);
                end
            end
        endcase
    end

    // A run press suppresses both a coincident step and a coincident terminal tick.
    always_comb begin
        cnt_en_d = 1'b0;
        if (!run_rise) begin
            if (state_q == ST_PAUSED) cnt_en_d = step_rise;
            else                      cnt_en_d = (presc_q == PRESC_LAST);
        end
        dir_d     = cnt_en_d ? dir_q : dir_level;
        running_d = (state_d == ST_RUN);
    end

    assign cnt_en  = cnt_en_q;
    assign cnt_dir = dir_q;
    assign running = running_q;

endmodule

// File: tb/tb_gray_tick_ctrl.sv
// Scoreboard bench for gray_tick_ctrl: a behavioural model predicts the outputs
// after each clock edge; a separate monitor pops and compares them.
module tb_gray_tick_ctrl;

    localparam int DIV_COUNT   = 4;
    localparam int DB_COUNT    = 3;
    localparam int SYNC_STAGES = 2;

`ifdef GRAY_TICK_AUTORUN_EN
    localparam bit AUTORUN = 1'b1;
`else
    localparam bit AUTORUN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_run = 1'b0;
    logic btn_step = 1'b0;
    logic dir_sw = 1'b0;
    logic cnt_en, cnt_dir, running;

    gray_tick_ctrl #(
        .DIV_COUNT   (DIV_COUNT),
        .DB_COUNT    (DB_COUNT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .dir_sw   (dir_sw),
        .cnt_en   (cnt_en),
        .cnt_dir  (cnt_dir),
        .running  (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic en;
        logic dir;
        logic run;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_no  = 0;

    // Reference model: index 0 = run button, 1 = step button, 2 = direction switch.
    bit hist   [3][SYNC_STAGES];  // raw samples, [0] is the oldest
    bit stable_m [3];
    bit prev_m   [3];
    int streak   [3];
    bit m_run;
    int m_age;
    bit m_en;
    bit m_dir;

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got en=%b dir=%b run=%b, want en=%b dir=%b run=%b",
                     name, got.en, got.dir, got.run, want.en, want.dir, want.run);
        end
    endtask

    task automatic model_edge(input bit r, input bit [2:0] raw);
        bit rise [3];
        bit tick;
        bit synced;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                for (int s = 0; s < SYNC_STAGES; s++) hist[i][s] = 1'b0;
                stable_m[i] = 1'b0;
                prev_m[i]   = 1'b0;
                streak[i]   = 0;
            end
            m_run = AUTORUN;
            m_age = 0;
            m_en  = 1'b0;
            m_dir = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) rise[i] = stable_m[i] && !prev_m[i];
            tick = 1'b0;
            if (m_run) begin
                if (rise[0]) begin
                    m_run = 1'b0;
                end else begin
                    m_age++;
                    tick = (m_age % DIV_COUNT) == 0;
                end
            end else begin
                if (rise[0]) begin
                    m_run = 1'b1;
                    m_age = 0;
                end else begin
                    tick = rise[1];
                end
            end
            if (!tick) m_dir = stable_m[2];
            m_en = tick;
            for (int i = 0; i < 3; i++) begin
                synced    = hist[i][0];
                prev_m[i] = stable_m[i];
                if (synced != stable_m[i]) begin
                    streak[i]++;
                    if (streak[i] == DB_COUNT) begin
                        stable_m[i] = synced;
                        streak[i]   = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
                for (int s = 0; s < SYNC_STAGES - 1; s++) hist[i][s] = hist[i][s+1];
                hist[i][SYNC_STAGES-1] = raw[i];
            end
        end
        exp_q.push_back('{en: m_en, dir: m_dir, run: m_run});
    endtask

    // Drive inputs away from the active edge and predict the outcome of the next edge.
    task automatic drive(input bit r, input bit run, input bit step, input bit dir, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst      = r;
            btn_run  = run;
            btn_step = step;
            dir_sw   = dir;
            model_edge(r, {dir, step, run});
        end
    endtask

    initial begin : monitor
        exp_t want;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = '{en: cnt_en, dir: cnt_dir, run: running};
                check($sformatf("edge %0d outputs", edge_no), got, want);
            end
        end
    end

    initial begin : stimulus
        int  hold;
        bit  d;
        drive(1, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 20);                 // idle after reset
        drive(0, 0, 1, 0, 10);                 // single step press
        drive(0, 0, 0, 0, 10);
        drive(0, 1, 0, 0, 2);                  // run glitch
        drive(0, 0, 0, 0, 8);
        drive(0, 1, 0, 0, 6);                  // accepted run press
        drive(0, 0, 0, 0, 20);
        drive(0, 0, 1, 0, 6);                  // step ignored in RUN
        drive(0, 0, 0, 0, 10);
        for (int k = 0; k < 8; k++) begin      // run presses at every prescaler phase
            drive(0, 0, 0, 0, k);
            drive(0, 1, 0, 0, 6);
            drive(0, 0, 0, 0, 10);
        end
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 1, 0, 6);                  // run and step together
        drive(0, 0, 0, 0, 6);
        d = 1'b0;
        for (int k = 0; k < 8; k++) begin      // direction changes at varied tick phases
            d = ~d;
            drive(0, 0, 0, d, 4 + k);
            drive(0, 0, 0, d, 3);
        end
        drive(0, 1, 1, 1, 3);                  // reset mid-debounce and mid-prescale
        drive(1, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 12);
        for (int k = 0; k < 500; k++) begin    // random phase
            hold = $urandom_range(1, 7);
            drive(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom), hold);
        end
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
